// File: rtl/cpu_pkg.sv
// Shared types and default widths for the data-cache controller.
package cpu_pkg;

  localparam int unsigned ADDRESS_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF    = 32;
  localparam int unsigned SET_WIDTH_DEF     = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESP   = 2'd2,
    ST_WRITE  = 2'd3
  } dc_state_e;

  // Big-endian byte lane: offset 0 is the most significant byte of the word.
  function automatic int unsigned lane_lsb(input logic [1:0] off, input int unsigned dw);
    return dw - 32'd8 - (32'(off) << 3);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped one-word-line storage: combinational read, synchronous write,
// single-cycle clear of every valid bit.
module dcache_array #(
  parameter int unsigned TAG_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SET_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [SET_WIDTH-1:0]  rd_set,
  output logic                  rd_valid,
  output logic [TAG_WIDTH-1:0]  rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [SET_WIDTH-1:0]  wr_set,
  input  logic [TAG_WIDTH-1:0]  wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int unsigned SETS = 1 << SET_WIDTH;

  logic [SETS-1:0]       valid;
  logic [TAG_WIDTH-1:0]  tag_mem  [SETS];
  logic [DATA_WIDTH-1:0] data_mem [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_set] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until valid is set, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_set]  <= wr_tag;
      data_mem[wr_set] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_set];
  assign rd_tag   = tag_mem[rd_set];
  assign rd_data  = data_mem[rd_set];

endmodule

// File: rtl/dcache_ctrl.sv
// Write-through, no-write-allocate direct-mapped data cache controller with
// one-word lines, big-endian byte access and load hit/miss counters.
module dcache_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned SET_WIDTH     = SET_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic                     cpu_byte,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic                     cpu_ready,
  output logic                     cpu_done,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  input  logic                     flush,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     mem_byte,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int unsigned TAG_WIDTH = ADDRESS_WIDTH - SET_WIDTH - 2;
  localparam int unsigned LSB_WIDTH = $clog2(DATA_WIDTH);

  dc_state_e state, state_n;

  logic                     req_we, req_byte, flush_pend;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;

  logic                     idle, take_flush, accept, hit;
  logic [SET_WIDTH-1:0]     rd_set;
  logic [TAG_WIDTH-1:0]     lookup_tag, rd_tag;
  logic                     rd_valid;
  logic [DATA_WIDTH-1:0]    rd_data, wr_data;
  logic                     wr_en;

  logic                     done_n, mem_req_n, mem_we_n, mem_byte_n, hit_inc, miss_inc;
  logic [DATA_WIDTH-1:0]    rdata_n, mem_wdata_n;
  logic [ADDRESS_WIDTH-1:0] mem_addr_n;

  function automatic logic [DATA_WIDTH-1:0] load_view(input logic [DATA_WIDTH-1:0] w,
                                                      input logic byt, input logic [1:0] off);
    logic [LSB_WIDTH-1:0] lsb;
    lsb = LSB_WIDTH'(lane_lsb(off, DATA_WIDTH));
    return byt ? DATA_WIDTH'(w[lsb +: 8]) : w;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] old,
                                                        input logic [DATA_WIDTH-1:0] wd,
                                                        input logic byt, input logic [1:0] off);
    logic [LSB_WIDTH-1:0]  lsb;
    logic [DATA_WIDTH-1:0] m;
    lsb = LSB_WIDTH'(lane_lsb(off, DATA_WIDTH));
    m = old;
    m[lsb +: 8] = wd[7:0];
    return byt ? m : wd;
  endfunction

  // Flush wins over a same-cycle request and is deferred while a transaction is in flight.
  assign idle       = (state == ST_IDLE);
  assign take_flush = idle && (flush || flush_pend);
  assign cpu_ready  = idle && !flush && !flush_pend;
  assign accept     = cpu_req && cpu_ready;

  // Look up with the live address while idle, with the latched one while busy.
  assign rd_set     = idle ? cpu_addr[SET_WIDTH+1:2] : req_addr[SET_WIDTH+1:2];
  assign lookup_tag = idle ? cpu_addr[ADDRESS_WIDTH-1:SET_WIDTH+2]
                           : req_addr[ADDRESS_WIDTH-1:SET_WIDTH+2];
  assign hit        = rd_valid && (rd_tag == lookup_tag);

  dcache_array #(
    .TAG_WIDTH (TAG_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .SET_WIDTH (SET_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (take_flush),
    .rd_set  (rd_set),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_set  (req_addr[SET_WIDTH+1:2]),
    .wr_tag  (req_addr[ADDRESS_WIDTH-1:SET_WIDTH+2]),
    .wr_data (wr_data)
  );

  always_comb begin
    state_n     = state;
    done_n      = 1'b0;
    rdata_n     = cpu_rdata;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_byte_n  = mem_byte;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    wr_en       = 1'b0;
    wr_data     = rd_data;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cpu_we) begin
            state_n     = ST_WRITE;
            mem_req_n   = 1'b1;
            mem_we_n    = 1'b1;
            mem_byte_n  = cpu_byte;
            mem_addr_n  = cpu_addr;
            mem_wdata_n = cpu_wdata;
          end else if (hit) begin
            state_n = ST_RESP;
            done_n  = 1'b1;
            rdata_n = load_view(rd_data, cpu_byte, cpu_addr[1:0]);
            hit_inc = 1'b1;
          end else begin
            state_n    = ST_REFILL;
            mem_req_n  = 1'b1;
            mem_we_n   = 1'b0;
            mem_byte_n = 1'b0;
            mem_addr_n = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
            miss_inc   = 1'b1;
          end
        end
      end
      ST_REFILL: begin
        if (mem_ack) begin
          state_n   = ST_RESP;
          mem_req_n = 1'b0;
          wr_en     = 1'b1;
          wr_data   = mem_rdata;
          done_n    = 1'b1;
          rdata_n   = load_view(mem_rdata, req_byte, req_addr[1:0]);
        end
      end
      ST_RESP: state_n = ST_IDLE;
      ST_WRITE: begin
        if (mem_ack) begin
          state_n   = ST_IDLE;
          mem_req_n = 1'b0;
          done_n    = 1'b1;
          wr_en     = hit;
          wr_data   = store_merge(rd_data, req_wdata, req_byte, req_addr[1:0]);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_we     <= 1'b0;
      req_byte   <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      flush_pend <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_byte   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state     <= state_n;
      cpu_done  <= done_n;
      cpu_rdata <= rdata_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_byte  <= mem_byte_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if (accept) begin
        req_we    <= cpu_we;
        req_byte  <= cpu_byte;
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
      end
      if (take_flush) flush_pend <= 1'b0;
      else if (flush) flush_pend <= 1'b1;
      if (hit_inc)  hit_count  <= hit_count + 32'd1;
      if (miss_inc) miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed table, corner sequences and
// randomized traffic against a transaction-level cache and memory model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, cpu_req, cpu_we, cpu_byte, flush, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, mem_rdata;
  logic        cpu_ready, cpu_done, mem_req, mem_we, mem_byte;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata, hit_count, miss_count;

  int checks = 0;
  int errors = 0;

  dcache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
    .mem_byte(mem_byte), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] bmem [int unsigned];
  int          ack_delay = 3;
  int          mreq_cnt = 0;
  logic [31:0] exp_maddr;
  logic        exp_mwe, exp_mbyte;

  function automatic logic [31:0] put_lane(input logic [31:0] w, input int off, input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[(24 - 8*off) +: 8] = b;
    return r;
  endfunction

  function automatic logic [31:0] get_lane(input logic [31:0] w, input int off);
    return {24'h0, w[(24 - 8*off) +: 8]};
  endfunction

  function automatic logic [31:0] backing(input logic [31:0] byte_addr);
    int unsigned w;
    w = byte_addr >> 2;
    return bmem.exists(w) ? bmem[w] : (w * 32'h9E37_79B1);
  endfunction

  initial begin : responder
    logic        pend, cw, cb;
    logic [31:0] ca, cd;
    int          cnt;
    pend = 1'b0; cnt = 0; cw = 1'b0; cb = 1'b0; ca = '0; cd = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (!pend) begin
        if (mem_req) begin
          pend = 1'b1;
          mreq_cnt++;
          cnt = (ack_delay > 0) ? ack_delay : int'($urandom_range(1, 4));
          ca = mem_addr; cw = mem_we; cb = mem_byte; cd = mem_wdata;
          chk("mem_addr", mem_addr, exp_maddr);
          chk("mem_we", 32'(mem_we), 32'(exp_mwe));
          chk("mem_byte", 32'(mem_byte), 32'(exp_mbyte));
        end
      end else begin
        chk("mem_stable", {mem_req, mem_we, mem_byte, 29'h0} ^ mem_addr ^ (cw ? mem_wdata : 32'h0),
            {1'b1, cw, cb, 29'h0} ^ ca ^ (cw ? cd : 32'h0));
        cnt--;
        if (cnt <= 0) begin
          mem_ack = 1'b1;
          pend = 1'b0;
          if (cw) bmem[ca >> 2] = cb ? put_lane(backing(ca), int'(ca[1:0]), cd[7:0]) : cd;
          else    mem_rdata = backing(ca);
        end
      end
    end
  end

  // ---------------- cache model ----------------
  logic        mvalid [64];
  logic [23:0] mtag   [64];
  logic [31:0] mdata  [64];
  logic [31:0] mhit = 0, mmiss = 0;

  task automatic model_clear();
    for (int s = 0; s < 64; s++) mvalid[s] = 1'b0;
  endtask

  task automatic do_op(input logic we, input logic byt, input logic [31:0] addr,
                       input logic [31:0] wd, input int flush_cyc,
                       output logic [31:0] rd, output int delta, output logic was_hit);
    int          n, set, m0;
    logic        hit, did_flush;
    logic [31:0] line, exp_rd;
    n = 0;
    while (!cpu_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("ready_wait", 32'(cpu_ready), 32'd1);
    set = int'(addr[7:2]);
    hit = mvalid[set] && (mtag[set] == addr[31:8]);
    line = hit ? mdata[set] : backing(addr);
    exp_rd = byt ? get_lane(line, int'(addr[1:0])) : line;
    exp_maddr = we ? addr : {addr[31:2], 2'b00};
    exp_mwe = we;
    exp_mbyte = we & byt;
    m0 = mreq_cnt;
    cpu_req = 1'b1; cpu_we = we; cpu_byte = byt; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n = 1; did_flush = 1'b0;
    while (!cpu_done && n < 40) begin
      if (n == flush_cyc) begin flush = 1'b1; did_flush = 1'b1; end
      @(posedge clk); #1;
      flush = 1'b0;
      n++;
    end
    chk("done_seen", 32'(cpu_done), 32'd1);
    rd = cpu_rdata;
    delta = mreq_cnt - m0;
    was_hit = hit;
    chk("mem_req_count", 32'(delta), (we || !hit) ? 32'd1 : 32'd0);
    if (!we) begin
      chk("load_rdata", cpu_rdata, exp_rd);
      if (hit) begin
        chk("hit_latency", 32'(n), 32'd1);
        mhit++;
      end else begin
        mmiss++;
        mvalid[set] = 1'b1; mtag[set] = addr[31:8]; mdata[set] = line;
      end
    end else if (hit) begin
      mdata[set] = byt ? put_lane(mdata[set], int'(addr[1:0]), wd[7:0]) : wd;
    end
    chk("hit_count", hit_count, mhit);
    chk("miss_count", miss_count, mmiss);
    @(posedge clk); #1;
    chk("done_pulse", 32'(cpu_done), 32'd0);
    if (did_flush) model_clear();
  endtask

  typedef struct {
    logic        we;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_hit;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    int          delta;
    logic        was_hit;

    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; flush = 1'b0;
    model_clear();
    bmem[32'h10000 >> 2] = 32'hDEAD_BEEF;

    #12;
    chk("rst_done", 32'(cpu_done), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_req", {29'h0, mem_req, mem_we, mem_byte}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_counts", hit_count | miss_count, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(cpu_ready), 32'd1);

    // Directed table: cold miss, hit, byte store, store no-allocate, aliasing.
    vecs[0] = '{1'b0, 1'b0, 32'h0001_0000, 32'h0,          1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b0, 32'h0001_0000, 32'h0,          1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0001_0002, 32'h0000_00AA,  1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0001_0000, 32'h0,          1'b1, 32'hDEAD_AAEF};
    vecs[4] = '{1'b1, 1'b0, 32'h0001_0100, 32'h1234_5678,  1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0001_0100, 32'h0,          1'b0, 32'h1234_5678};
    vecs[6] = '{1'b0, 1'b0, 32'h0001_0000, 32'h0,          1'b0, 32'hDEAD_AAEF};
    vecs[7] = '{1'b0, 1'b1, 32'h0001_0001, 32'h0,          1'b1, 32'h0000_00AD};
    vecs[8] = '{1'b0, 1'b1, 32'h0001_0003, 32'h0,          1'b1, 32'h0000_00EF};
    ack_delay = 3;
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].we, vecs[i].byt, vecs[i].addr, vecs[i].wd, -1, rd, delta, was_hit);
      chk($sformatf("vec%0d_memreq", i), 32'(delta), (vecs[i].we || !vecs[i].exp_hit) ? 32'd1 : 32'd0);
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end

    // Flush together with a request in IDLE: request dropped, line invalidated.
    flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 32'h0001_0000;
    #1;
    chk("flush_ready_low", 32'(cpu_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; cpu_req = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_done", {30'h0, cpu_done, mem_req}, 32'd0);
      @(posedge clk); #1;
    end
    do_op(1'b0, 1'b0, 32'h0001_0000, 32'h0, -1, rd, delta, was_hit);
    chk("flush_then_miss", 32'(was_hit), 32'd0);

    // Flush while a refill is outstanding: deferred, then invalidates.
    do_op(1'b0, 1'b0, 32'h0001_0010, 32'h0, 1, rd, delta, was_hit);
    do_op(1'b0, 1'b0, 32'h0001_0010, 32'h0, -1, rd, delta, was_hit);
    chk("pend_flush_miss", 32'(was_hit), 32'd0);

    // Reset in the middle of a refill abandons it.
    ack_delay = 6;
    exp_maddr = 32'h0002_0000; exp_mwe = 1'b0; exp_mbyte = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 32'h0002_0000;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("refill_mem_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_counts", hit_count | miss_count, 32'd0);
    chk("rst_mid_done", 32'(cpu_done), 32'd0);
    @(posedge clk); #4 rst_n = 1'b1;
    @(posedge clk); #1;
    model_clear(); mhit = 0; mmiss = 0;
    do_op(1'b0, 1'b0, 32'h0002_0000, 32'h0, -1, rd, delta, was_hit);
    chk("rst_then_miss", miss_count, 32'd1);

    // Randomized traffic over two aliasing tags and four sets.
    ack_delay = 0;
    for (int i = 0; i < 300; i++) begin
      logic        we, byt;
      logic [31:0] addr, wd;
      int          fc;
      we   = ($urandom_range(0, 2) == 0);
      byt  = $urandom_range(0, 1) == 1;
      addr = 32'h0001_0000 + (32'($urandom_range(0, 1)) << 8) + (32'($urandom_range(0, 3)) << 2);
      if (byt) addr = addr + 32'($urandom_range(0, 3));
      wd   = $urandom;
      fc   = ($urandom_range(0, 9) == 0) ? 1 : -1;
      if ($urandom_range(0, 15) == 0) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
      end
      do_op(we, byt, addr, wd, fc, rd, delta, was_hit);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, meaning CPU/memory byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width.
REQ-003 SHALL have parameter SET_WIDTH, default 6, meaning log2 of set count (64 one-word lines); tag = ADDRESS_WIDTH-SET_WIDTH-2 bits.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cpu_req, input, 1, memory-stage access request.
REQ-007 SHALL have port cpu_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port cpu_byte, input, 1, 1 = byte access, 0 = word access.
REQ-009 SHALL have port cpu_addr, input, ADDRESS_WIDTH, byte address.
REQ-010 SHALL have port cpu_wdata, input, DATA_WIDTH, store data (byte stores use [7:0]).
REQ-011 SHALL have port cpu_ready, output, 1, high only in IDLE with no flush pending.
REQ-012 SHALL have port cpu_done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port cpu_rdata, output, DATA_WIDTH, load result, valid while cpu_done.
REQ-014 SHALL have port flush, input, 1, invalidate all lines.
REQ-015 SHALL have ports mem_req/mem_we/mem_byte (output, 1), mem_addr (output, ADDRESS_WIDTH), mem_wdata (output, DATA_WIDTH): downstream data-memory request.
REQ-016 SHALL have ports mem_ack (input, 1) and mem_rdata (input, DATA_WIDTH): memory completion and read word.
REQ-017 SHALL have ports hit_count, miss_count, output, 32, load hit/miss counters.

Function
REQ-018 SHALL implement FSM states IDLE, REFILL, RESP, WRITE.
REQ-019 SHALL accept a request when cpu_req && cpu_ready, latching we, byte, addr, wdata.
REQ-020 SHALL index by addr[SET_WIDTH+1:2]; hit = valid[set] && tag[set]==addr[ADDRESS_WIDTH-1:SET_WIDTH+2].
REQ-021 Load hit: SHALL go IDLE->RESP, pulse cpu_done next cycle (latency 1), increment hit_count.
REQ-022 Load miss: SHALL go IDLE->REFILL, drive mem_req=1, mem_we=0, mem_byte=0, mem_addr word-aligned; increment miss_count at acceptance.
REQ-023 In REFILL, on mem_ack SHALL write mem_rdata, tag, valid=1 into the set and go RESP.
REQ-024 Store (hit or miss): SHALL go WRITE, drive mem_req=1, mem_we=1, mem_byte, mem_addr=cpu_addr unmodified, mem_wdata=cpu_wdata (write-through).
REQ-025 In WRITE, on mem_ack SHALL update the line only if hit: word store replaces word; byte store replaces one big-endian lane (offset 0 -> [31:24], offset 3 -> [7:0]); store miss SHALL NOT allocate. Then go IDLE with cpu_done pulse that cycle.
REQ-026 RESP SHALL pulse cpu_done for one cycle and return to IDLE.
REQ-027 Byte load SHALL return the big-endian lane zero-extended in [7:0]; word load returns full word.
REQ-028 mem_req and all mem_* outputs SHALL stay stable from assertion until the cycle mem_ack is sampled; mem_ack outside REFILL/WRITE SHALL be ignored.
REQ-029 flush SHALL be taken only in IDLE, clearing all valid bits in one cycle; it has priority over a simultaneous cpu_req (cpu_ready low that cycle); flush arriving while busy SHALL be held pending until IDLE.
REQ-030 Counters SHALL wrap modulo 2^32; stores SHALL NOT count.

Reset
REQ-031 On rst_n low SHALL immediately force IDLE, all valid bits 0, cpu_done=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_byte=0, mem_addr=0, mem_wdata=0, counters 0, flush-pending 0; reset mid-REFILL/WRITE abandons the transaction with no line update.
REQ-032 Tag and data arrays SHALL NOT require reset.

Structure
REQ-033 State enum and default width constants SHALL live in shared package cpu_pkg.
REQ-034 Tag/data/valid storage SHALL be one sub-module, dcache_array (combinational read, synchronous write, parallel valid clear).

Verification
REQ-035 Load 0x10000 cold (mem_rdata=0xDEADBEEF after 3-cycle ack) -> one mem_req, cpu_done with 0xDEADBEEF, miss_count=1; repeat -> no mem_req, done 1 cycle later, hit_count=1.
REQ-036 Byte store 0xAA to 0x10002 after refill -> mem_req, we=1, byte=1, addr 0x10002; then word load 0x10000 hit returns 0xDEADAAEF.
REQ-037 Store to uncached 0x10100 then load 0x10100 -> load misses (no allocate), miss_count increments.
REQ-038 Flush and cpu_req same IDLE cycle -> request not accepted, next load of 0x10000 misses.
REQ-039 rst_n low during REFILL before ack -> mem_req drops immediately, later load of same address misses.
REQ-040 Alias 0x10000 vs 0x10100 (same set, different tag) -> second load misses and evicts first.
